// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the rising-to-rising period of async sig_i in clk_i cycles.
// Define CLK_PERIOD_METER_AVG_EN to average four consecutive periods per measurement.
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             sig_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] div_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = 1;
  logic [1:0]             r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_div;
  logic                   r_ovf;
  logic                   r_done;
  logic                   w_rise;
  logic                   w_tmo;
`ifdef CLK_PERIOD_METER_AVG_EN
  logic [CNT_W+1:0]       r_acc;
  logic [1:0]             r_n;
  logic [CNT_W+1:0]       w_sum;
  assign w_sum = r_acc + {2'b00, r_cnt};
`endif
  assign w_rise   = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_tmo    = !w_rise && r_cnt == MAX;
  assign busy_o   = r_state != IDLE;
  assign done_o   = r_done;
  assign ovf_o    = r_ovf;
  assign period_o = r_period;
  assign div_o    = r_div;
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sync   <= '0;
      r_hist   <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_div    <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
      r_acc    <= '0;
      r_n      <= '0;
`endif
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_i};
      r_hist <= r_sync[SYNC_STAGES-1];
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start_i) begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
      end else if (w_tmo) begin
        // saturate instead of wrapping so a stuck input reads as all-ones
        r_period <= MAX;
        r_div    <= MAX >> 1;
        r_ovf    <= 1'b1;
        r_done   <= 1'b1;
        r_state  <= IDLE;
      end else if (!w_rise) begin
        r_cnt <= r_cnt + ONE;
      end else if (r_state == WAIT) begin
        r_cnt   <= ONE;
        r_state <= MEAS;
`ifdef CLK_PERIOD_METER_AVG_EN
        r_acc   <= '0;
        r_n     <= '0;
      end else if (r_n != 2'd3) begin
        r_cnt <= ONE;
        r_acc <= w_sum;
        r_n   <= r_n + 2'd1;
      end else begin
        r_period <= w_sum[CNT_W+1:2];
        r_div    <= {1'b0, w_sum[CNT_W+1:3]};
        r_ovf    <= 1'b0;
        r_done   <= 1'b1;
        r_state  <= IDLE;
      end
`else
      end else begin
        r_period <= r_cnt;
        r_div    <= r_cnt >> 1;
        r_ovf    <= 1'b0;
        r_done   <= 1'b1;
        r_state  <= IDLE;
      end
`endif
    end
  end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed and random period measurements checked against ideal periods.
module tb_clk_period_meter;
  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int TMO   = (1 << CNT_W) - 1;
`ifdef CLK_PERIOD_METER_AVG_EN
  localparam int NP = 4;
`else
  localparam int NP = 1;
`endif
  logic             clk = 0;
  logic             rst = 1;
  logic             sig_i = 0;
  logic             start_i = 0;
  logic             busy_o, done_o, ovf_o;
  logic [CNT_W-1:0] period_o, div_o;
  int               n_chk = 0;
  int               n_fail = 0;
  int               per[4] = '{0, 0, 0, 0};
  int               wave_id = 0;

  clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk), .rst(rst), .sig_i(sig_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o),
    .period_o(period_o), .div_o(div_o)
  );

  always #5 clk = ~clk;

  // waveform generator: per[k] cycles per period, high for per[k]/2; 0 holds the line low
  initial begin
    int k = 0;
    int ph = 0;
    int id = 0;
    forever begin
      @(negedge clk);
      if (id != wave_id) begin
        id = wave_id;
        k = 0;
        ph = 0;
      end
      if (per[k] == 0) sig_i = 0;
      else begin
        sig_i = (ph < per[k] / 2) ? 1'b1 : 1'b0;
        ph++;
        if (ph >= per[k]) begin
          ph = 0;
          k = (k + 1) % 4;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_wave(input int a, input int b, input int c, input int d);
    per = '{a, b, c, d};
    wave_id++;
  endtask

  function automatic int bound_for(input int p);
    return (NP + 1) * p + SYNC + 4;
  endfunction

  task automatic go(input string tag);
    @(negedge clk) start_i = 1;
    @(negedge clk) start_i = 0;
    chk({tag, "_busy"}, busy_o, 1);
  endtask

  task automatic wait_done(input string tag, input int exp_p, input bit exp_o, input int bound);
    int lat = 0;
    while (done_o !== 1'b1 && lat < bound) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_period"}, period_o, exp_p);
    chk({tag, "_div"}, div_o, exp_p >> 1);
    chk({tag, "_ovf"}, ovf_o, exp_o);
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, "_pulse"}, done_o, 0);
    chk({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic normal(input string tag, input int p);
    set_wave(p, p, p, p);
    repeat ($urandom_range(SYNC + 2, SYNC + 2 + p)) @(negedge clk);
    go(tag);
    wait_done(tag, p, 0, bound_for(p));
    after_done(tag);
  endtask

  initial begin
    int nd;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_period", period_o, 0);
    chk("rst_div", div_o, 0);
    rst = 0;
    normal("p10", 10);
    normal("div7", 14);
    normal("div1", 2);
    // stuck-low input must time out with saturated results
    set_wave(0, 0, 0, 0);
    repeat (6) @(negedge clk);
    go("tmo");
    wait_done("tmo", TMO, 1, 600);
    after_done("tmo");
    normal("p20", 20);
    // start held high for the whole measurement, then still high in the done cycle
    set_wave(30, 30, 30, 30);
    repeat (7) @(negedge clk);
    @(negedge clk) start_i = 1;
    wait_done("rep", 30, 0, bound_for(30) + 2);
    @(negedge clk) start_i = 0;
    chk("rep_pulse", done_o, 0);
    chk("rep_rearm", busy_o, 1);
    wait_done("rep2", 30, 0, bound_for(30));
    after_done("rep2");
    // reset during MEASURE: line held low, start, then release the waveform
    set_wave(0, 0, 0, 0);
    repeat (6) @(negedge clk);
    go("rstm");
    set_wave(30, 30, 30, 30);
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk) rst = 0;
    chk("rstm_busy", busy_o, 0);
    chk("rstm_period", period_o, 0);
    chk("rstm_div", div_o, 0);
    chk("rstm_ovf", ovf_o, 0);
    nd = 0;
    repeat (200) begin
      @(negedge clk);
      if (done_o === 1'b1) nd++;
    end
    chk("rstm_nodone", nd, 0);
    go("rstm2");
    wait_done("rstm2", 30, 0, bound_for(30));
    after_done("rstm2");
    for (int i = 0; i < 6; i++) normal("rand", $urandom_range(2, 60));
`ifdef CLK_PERIOD_METER_AVG_EN
    set_wave(10, 11, 10, 11);
    repeat (5) @(negedge clk);
    go("avg");
    wait_done("avg", 10, 0, 80);
    after_done("avg");
    set_wave(0, 0, 0, 0);
    repeat (6) @(negedge clk);
    go("avg_tmo");
    set_wave(20, 20, 300, 20);
    wait_done("avg_tmo", TMO, 1, 2000);
    after_done("avg_tmo");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Measures the period of an external or derived clock/signal `sig_i` in `clk_i` cycles.
- Reports the matching `clkdiv` divisor value: `clkdiv` toggles every `div` cycles, so period = 2*div.
- Used by the sniffer to auto-detect target bus clock rates and to self-check the sample-clock divider in loopback.
- Single-shot measurement started by `start_i`, ending with a one-cycle `done_o` pulse.

Parameters:
- CNT_W, 16, counter and result width; matches the `clkdiv` `div` width.
- SYNC_STAGES, 2, synchronizer flops on `sig_i`; minimum 2.

Ports:
- clk_i  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- sig_i  in  1  asynchronous signal under measurement.
- start_i  in  1  start request; honoured only in IDLE.
- busy_o  out  1  high while in WAIT or MEASURE.
- done_o  out  1  one-cycle pulse, measurement finished.
- ovf_o  out  1  last measurement timed out; held until next done_o.
- period_o  out  CNT_W  rising-to-rising period in clk_i cycles; held until next done_o.
- div_o  out  CNT_W  period_o >> 1 (floor); equivalent `clkdiv` div.

Behaviour:
- Input path: SYNC_STAGES-flop synchronizer, then one history flop. `rise` = synced & ~history.
  - Fixed latency SYNC_STAGES+1 cycles, identical for every edge, so no effect on the period.
  - Sampling jitter is ±1 cycle.
- Reset: state=IDLE, busy_o=0, done_o=0, ovf_o=0, period_o=0, div_o=0, counter=0, synchronizer and history flops=0.
- IDLE:
  - start_i=1: counter<=0, go to WAIT.
  - start_i is accepted in the same cycle done_o is high, because the FSM is already IDLE then.
- WAIT (armed, waiting for first rising edge):
  - counter increments each cycle.
  - On rise: counter<=1, go to MEASURE.
  - If counter reaches 2^CNT_W-1 with no rise: timeout.
- MEASURE:
  - counter increments each cycle.
  - On rise: period_o<=counter, div_o<=counter>>1, ovf_o<=0, done_o<=1 (next cycle), go to IDLE.
  - Rises at cycles t and t+N give period_o=N.
  - If counter reaches 2^CNT_W-1 with no rise: timeout.
- Timeout (WAIT or MEASURE): period_o<=all ones, div_o<=all ones>>1, ovf_o<=1, done_o<=1, go to IDLE. The counter never wraps.
- Minimum measurable period is 2 (one cycle high, one low after sync). Narrower pulses may be missed; no error is flagged.
- start_i while busy_o=1: ignored; the measurement in progress is unaffected.
- rst mid-operation: immediate return to IDLE, all outputs take reset values, no done_o pulse.
- done_o is registered and high for exactly one cycle per completed measurement.

Optional Feature:
- Macro: CLK_PERIOD_METER_AVG_EN.
- Defined:
  - MEASURE spans 4 consecutive periods (5 rising edges) with a CNT_W+2-bit accumulator.
  - period_o = accumulator>>2 (floor); div_o = period_o>>1.
  - The per-period counter restarts at 1 on each intermediate rise.
  - The timeout applies to each individual period.
  - Any timeout aborts with ovf_o=1 as above.
- Undefined: single-period measurement as described; no accumulator logic is present.

Test Plan:
- sig_i square wave, period 10 cycles, random phase; pulse start_i -> done_o after ≤ 2 periods + SYNC_STAGES + 2 cycles; period_o=10, div_o=5, ovf_o=0.
- sig_i driven by `clkdiv` div=7 on the same clk_i -> period_o=14, div_o=7; repeat with div=1 -> period_o=2, div_o=1.
- CNT_W=8, sig_i held 0, start_i -> done_o about 255 cycles later, ovf_o=1, period_o=8'hFF, div_o=8'h7F. Then a normal start with period 20 -> ovf_o=0, period_o=20.
- start_i re-pulsed every cycle during a period-30 measurement -> exactly one done_o, period_o=30. start_i in the done_o cycle -> second measurement begins, busy_o=1 the next cycle.
- rst asserted mid-MEASURE -> next cycle busy_o=0, period_o=0, div_o=0, and no done_o. A new start then measures correctly.
- With CLK_PERIOD_METER_AVG_EN, sig_i periods 10,11,10,11 -> period_o=10, div_o=5. A 300-cycle gap in the third period with CNT_W=8 -> ovf_o=1.
